examp_req_capture: RTL

EXAMP_REQ_CAPTURE -- requirements
Module: examp_req_capture

---
 rtl/examp_req_capture.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/examp_req_capture.sv
// examp_req_capture
// Captures single-cycle requests from NCH channels into per-channel holding
// registers, arbitrates pending channels round-robin into a shared show-ahead
// FIFO of {channel, data}, and counts requests that arrive while their
// channel is still waiting to be granted.
//
// Optional feature: define EXAMP_REQ_CAPTURE_TIMESTAMP_EN to add a free-running
// TSW-bit timestamp that is captured with each request and presented on out_ts.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous reset, active low
//   req_val   per-channel request valid
//   req_dat   per-channel data, channel i in [i*DW +: DW]
//   out_val   FIFO head valid
//   out_rdy   consumer accepts head
//   out_dat   head data
//   out_ch    head source channel
//   level     FIFO occupancy
//   drop_cnt  saturating count of dropped requests
//   overflow  sticky drop flag
//   clr       synchronous clear of drop_cnt and overflow
//   out_ts    head timestamp (timestamp build only)
module examp_req_capture #(
   parameter  int NCH   = 4,
   parameter  int DW    = 8,
   parameter  int DEPTH = 8,
   parameter  int TSW   = 16,
   localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int LW    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NCH-1:0]    req_val,
   input  logic [NCH*DW-1:0] req_dat,
   output logic              out_val,
   input  logic              out_rdy,
   output logic [DW-1:0]     out_dat,
   output logic [CW-1:0]     out_ch,
   output logic [LW-1:0]     level,
   output logic [15:0]       drop_cnt,
   output logic              overflow,
   input  logic              clr
`ifdef EXAMP_REQ_CAPTURE_TIMESTAMP_EN
   ,
   output logic [TSW-1:0]    out_ts
`endif
);

   localparam int PW = $clog2(DEPTH);

   logic              armed;
   logic [NCH-1:0]    pend;
   logic [DW-1:0]     hold_dat [NCH];
   logic [CW-1:0]     rr_prio;

   logic [CW-1:0]     mem_ch  [DEPTH];
   logic [DW-1:0]     mem_dat [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;

   logic              hi_vld;
   logic              lo_vld;
   logic [CW-1:0]     hi_ch;
   logic [CW-1:0]     lo_ch;
   logic [CW-1:0]     gnt_ch;
   logic              do_wr;
   logic              do_rd;
   logic              can_wr;
   logic [NCH-1:0]    gnt_vec;
   logic [NCH-1:0]    load_vec;
   logic [NCH-1:0]    drop_vec;
   logic [4:0]        drop_sum;
   logic [16:0]       drop_nxt;

   // Round-robin pick: the lowest pending channel at or above rr_prio wins;
   // otherwise the lowest pending channel below it. Scanning downward lets the
   // last hit be the lowest index without a break.
   always_comb begin
      hi_vld = 1'b0;
      lo_vld = 1'b0;
      hi_ch  = '0;
      lo_ch  = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (pend[i]) begin
            if (CW'(i) >= rr_prio) begin
               hi_vld = 1'b1;
               hi_ch  = CW'(i);
            end else begin
               lo_vld = 1'b1;
               lo_ch  = CW'(i);
            end
         end
      end
      do_rd  = out_val & out_rdy;
      // A full FIFO still takes a write when the head leaves in the same cycle.
      can_wr = (level < LW'(DEPTH)) | do_rd;
      do_wr  = (hi_vld | lo_vld) & can_wr;
      gnt_ch = hi_vld ? hi_ch : lo_ch;
   end

   // armed stays low for the first edge after reset so req_val is ignored there.
   always_comb begin
      gnt_vec  = '0;
      load_vec = '0;
      drop_vec = '0;
      drop_sum = '0;
      for (int i = 0; i < NCH; i++) begin
         gnt_vec[i]  = do_wr & (gnt_ch == CW'(i));
         load_vec[i] = armed & req_val[i] & (~pend[i] | gnt_vec[i]);
         drop_vec[i] = armed & req_val[i] & pend[i] & ~gnt_vec[i];
         drop_sum    = drop_sum + 5'(drop_vec[i]);
      end
      drop_nxt = {1'b0, drop_cnt} + {12'd0, drop_sum};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed    <= 1'b0;
         pend     <= '0;
         rr_prio  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         drop_cnt <= '0;
         overflow <= 1'b0;
      end else begin
         armed <= 1'b1;
         pend  <= (pend & ~gnt_vec) | load_vec;
         if (do_wr) begin
            rr_prio <= (gnt_ch == CW'(NCH - 1)) ? '0 : gnt_ch + CW'(1);
            wr_ptr  <= wr_ptr + PW'(1);
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({do_wr, do_rd})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
         if (clr) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
         end else if (drop_sum != '0) begin
            drop_cnt <= drop_nxt[16] ? 16'hFFFF : drop_nxt[15:0];
            overflow <= 1'b1;
         end
      end
   end

   // Data storage carries no reset; validity is tracked by pend and level.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NCH; i++) begin
         if (load_vec[i]) begin
            hold_dat[i] <= req_dat[i*DW +: DW];
         end
      end
      if (do_wr) begin
         mem_ch[wr_ptr]  <= gnt_ch;
         mem_dat[wr_ptr] <= hold_dat[gnt_ch];
      end
   end

   // Head is forced to zero while empty, which also covers reset.
   assign out_val = (level != '0);
   assign out_dat = out_val ? mem_dat[rd_ptr] : '0;
   assign out_ch  = out_val ? mem_ch[rd_ptr]  : '0;

`ifdef EXAMP_REQ_CAPTURE_TIMESTAMP_EN
   logic [TSW-1:0] ts_cnt;
   logic [TSW-1:0] hold_ts [NCH];
   logic [TSW-1:0] mem_ts  [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_cnt <= '0;
      end else begin
         ts_cnt <= ts_cnt + TSW'(1);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NCH; i++) begin
         if (load_vec[i]) begin
            hold_ts[i] <= ts_cnt;
         end
      end
      if (do_wr) begin
         mem_ts[wr_ptr] <= hold_ts[gnt_ch];
      end
   end

   assign out_ts = out_val ? mem_ts[rd_ptr] : '0;
`endif

endmodule
